// File: rtl/dig_pkg.sv
// Shared constants for the 8-digit 7-segment display controller.
// Register offsets, hex7 glyph table and blank/reset values.
package dig_pkg;

  localparam logic [31:0] DIG_OFF_DATA = 32'h0;
  localparam logic [31:0] DIG_OFF_CTRL = 32'h4;

  localparam logic [7:0] DIG_BLANK   = 8'hFF;
  localparam logic [7:0] DIG_EN_ALL  = 8'hFF;
  localparam logic [7:0] DIG_DP_NONE = 8'h00;

  // Active-high {g,f,e,d,c,b,a}, entry i is the glyph for nibble i
  localparam logic [15:0][6:0] HEX7_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] dig_sel(
    input logic [2:0] idx
  );
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to 7-segment glyph decoder.
// Output is active-high {g,f,e,d,c,b,a}.
module hex_to_seg7
  import dig_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX7_LUT[nib];

endmodule

// File: rtl/dig_display_ctrl.sv
// Bus responder that scans 8 hex digits onto shared segment lines.
// Optional CTRL register (digit/dp masks) enabled by DIG_CTRL_REG_EN.
module dig_display_ctrl
  import dig_pkg::*;
#(
  parameter int SCAN_DIV = 2000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  logic [31:0]      data_q;
  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       dig_idx;
  logic [7:0]       en_mask;
  logic [7:0]       dp_mask;
  logic [3:0]       nib;
  logic [6:0]       hex;
  logic             wr;
  logic             wr_data;
  logic             scan_wrap;

  assign wr        = |we;
  assign wr_data   = wr && (addr[2] == DIG_OFF_DATA[2]);
  assign scan_wrap = scan_cnt == CNT_W'(SCAN_DIV - 1);
  assign nib       = data_q[{dig_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nib (nib),
    .seg (hex)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (wr_data) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) data_q[8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

`ifdef DIG_CTRL_REG_EN
  logic wr_ctrl;
  logic unused_addr;

  assign wr_ctrl     = wr && (addr[2] == DIG_OFF_CTRL[2]);
  assign unused_addr = ^{addr[31:3], addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      en_mask <= DIG_EN_ALL;
      dp_mask <= DIG_DP_NONE;
    end else if (wr_ctrl) begin
      if (we[0]) en_mask <= wdata[7:0];
      if (we[1]) dp_mask <= wdata[15:8];
    end
  end
`else
  logic unused_addr;

  assign unused_addr = ^{addr[31:3], addr[1:0]};
  assign en_mask     = DIG_EN_ALL;
  assign dp_mask     = DIG_DP_NONE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // Both outputs register on the same edge so enables and segments never skew
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en <= DIG_BLANK;
      seg    <= DIG_BLANK;
    end else begin
      dig_en <= en_mask[dig_idx] ? dig_sel(dig_idx) : DIG_BLANK;
      seg    <= {~dp_mask[dig_idx], ~hex};
    end
  end

endmodule

// File: tb/tb_dig_display_ctrl.sv
// Directed, table-driven bench for dig_display_ctrl with SCAN_DIV=4.
// Expected glyphs come from a bench-local hex7 table.
module tb_dig_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  we = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [6:0] lut [16];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  dig_display_ctrl #(
    .SCAN_DIV (4),
    .CNT_W    (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .dig_en (dig_en),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sel(input int d);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << d);
  endfunction

  function automatic logic [7:0] glyph(input logic [31:0] d, input int k);
    logic [3:0] n;
    n = d[4*k +: 4];
    return {1'b1, ~lut[n]};
  endfunction

  task automatic rst_write(input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] wd);
    rst = 1'b1;
    we = '0;
    tick();
    rst = 1'b0;
    addr = a;
    we = w;
    wdata = wd;
    tick();
    we = '0;
  endtask

  task automatic walk(input logic [31:0] exp_data, input int v);
    int d;
    for (int j = 0; j < 32; j++) begin
      tick();
      d = ((j + 1) >> 2) & 7;
      chk($sformatf("walk%0d_en_j%0d", v, j), dig_en, sel(d));
      chk($sformatf("walk%0d_seg_j%0d", v, j), seg, glyph(exp_data, d));
    end
  endtask

  initial begin
    int d;
    lut[0]  = 7'h3F; lut[1]  = 7'h06; lut[2]  = 7'h5B; lut[3]  = 7'h4F;
    lut[4]  = 7'h66; lut[5]  = 7'h6D; lut[6]  = 7'h7D; lut[7]  = 7'h07;
    lut[8]  = 7'h7F; lut[9]  = 7'h6F; lut[10] = 7'h77; lut[11] = 7'h7C;
    lut[12] = 7'h39; lut[13] = 7'h5E; lut[14] = 7'h79; lut[15] = 7'h71;

    vecs[0] = '{32'h0, 4'hF, 32'h89AB_CDEF, 32'h89AB_CDEF};
    vecs[1] = '{32'h0, 4'hF, 32'h7654_3210, 32'h7654_3210};
    vecs[2] = '{32'h0, 4'b0010, 32'hFFFF_5AFF, 32'h0000_5A00};
    vecs[3] = '{32'h0, 4'b1001, 32'hAABB_CCDD, 32'hAA00_00DD};
    vecs[4] = '{32'h0, 4'b0000, 32'h1234_5678, 32'h0000_0000};
    vecs[5] = '{32'h1000_00F8, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    // Reset state, then digit 0 showing '0'
    rst = 1'b1;
    tick();
    chk("rst_en", dig_en, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    rst = 1'b0;
    tick();
    chk("post_rst_en", dig_en, 8'hFE);
    chk("post_rst_seg", seg, 8'hC0);

    for (int v = 0; v < 6; v++) begin
      rst_write(vecs[v].addr, vecs[v].we, vecs[v].wdata);
      walk(vecs[v].exp_data, v);
    end

    // Write on the same edge the index wraps 7 -> 0
    rst_write(32'h0, 4'h0, 32'h0);
    repeat (30) tick();
    addr = 32'h0;
    we = 4'b0001;
    wdata = 32'h0000_000F;
    tick();
    we = '0;
    chk("wrap_last_en", dig_en, 8'h7F);
    chk("wrap_last_seg", seg, 8'hC0);
    tick();
    chk("wrap_first_en", dig_en, 8'hFE);
    chk("wrap_first_seg", seg, 8'h8E);

    // Reset mid-scan at digit 5, scan_cnt 2
    rst_write(32'h0, 4'hF, 32'h1111_1111);
    repeat (21) tick();
    chk("mid_pre_en", dig_en, 8'hDF);
    chk("mid_pre_seg", seg, 8'hF9);
    rst = 1'b1;
    tick();
    chk("mid_rst_en", dig_en, 8'hFF);
    chk("mid_rst_seg", seg, 8'hFF);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid_d0_en_%0d", c), dig_en, 8'hFE);
      chk($sformatf("mid_d0_seg_%0d", c), seg, 8'hC0);
    end
    tick();
    chk("mid_d1_en", dig_en, 8'hFD);

    // CTRL write: blank digits 0-3, dp on digit 0
    rst_write(32'h4, 4'b0011, 32'h0000_01F0);
    for (int j = 0; j < 32; j++) begin
      tick();
      d = ((j + 1) >> 2) & 7;
`ifdef DIG_CTRL_REG_EN
      if (d < 4) begin
        chk($sformatf("ctrl_blank_j%0d", j), dig_en, 8'hFF);
      end else begin
        chk($sformatf("ctrl_en_j%0d", j), dig_en, sel(d));
        chk($sformatf("ctrl_seg_j%0d", j), seg, 8'hC0);
      end
`else
      chk($sformatf("ctrl_en_j%0d", j), dig_en, sel(d));
      chk($sformatf("ctrl_seg_j%0d", j), seg, 8'hC0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
